// File: rtl/pipe_ctrl_regs_pkg.sv
// Shared types for the pipeline control registers: bubble instruction,
// forward-select codes and the execute-stage control bundle.
package pipe_pkg;

  // addi x0, x0, 0 -- the canonical RV32I bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Forward source select as encoded by the hazard unit; 2'b11 is unused
  // and falls back to the register value.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  // Control fields carried from decode into execute.
  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [2:0] ALUControl;
    logic       ALUSrc;
  } ctrl_e_t;

  // All-zero control word: no register write, no memory write, no jump or branch.
  localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_regs_if.sv
// Hazard-control interface: stall/flush strobes and forward selects
// driven by the hazard unit and consumed by the pipeline registers.
interface pipe_ctrl_regs_if;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  modport master (
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/pipe_ctrl_regs_fwd_mux3.sv
// 3:1 operand forwarding select; any unrecognised code picks the register value.
module fwd_mux3
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] reg_val,
  input  logic [WIDTH-1:0] mem_val,
  input  logic [WIDTH-1:0] wb_val,
  output logic [WIDTH-1:0] y
);

  // Pick the forwarding source for this operand.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves y unassigned (no latch).
    y = reg_val;
    case (sel)
      FWD_MEM: y = mem_val;
      FWD_WB:  y = wb_val;
      default: y = reg_val;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Fetch PC, IF/ID and ID/EX pipeline registers with execute-stage
// operand forwarding, controlled by the hazard unit.
module pipe_ctrl_regs
  import pipe_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               REG_AW   = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_ctrl_regs_if.slave   hz,
  input  logic [WIDTH-1:0]  PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [WIDTH-1:0]  PCPlus4F,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [2:0]        ALUControlD,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  ImmExtD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic [WIDTH-1:0]  ALUResultM,
  input  logic [WIDTH-1:0]  ResultW,
  output logic [WIDTH-1:0]  PCF,
  output logic [31:0]       InstrD,
  output logic [WIDTH-1:0]  PCD,
  output logic [WIDTH-1:0]  PCPlus4D,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [2:0]        ALUControlE,
  output logic [WIDTH-1:0]  PCE,
  output logic [WIDTH-1:0]  PCPlus4E,
  output logic [WIDTH-1:0]  ImmExtE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [WIDTH-1:0]  SrcAE,
  output logic [WIDTH-1:0]  WriteDataE
);

  ctrl_e_t          ctrl_e;
  ctrl_e_t          ctrl_d;
  logic [WIDTH-1:0] rd1_e;
  logic [WIDTH-1:0] rd2_e;

  assign ctrl_d = '{RegWrite:   RegWriteD,
                    ResultSrc:  ResultSrcD,
                    MemWrite:   MemWriteD,
                    Jump:       JumpD,
                    Branch:     BranchD,
                    ALUControl: ALUControlD,
                    ALUSrc:     ALUSrcD};

  // Fetch PC: advance to the next PC unless fetch is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else if (!hz.StallF) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      PCF <= PCNextF;
    end
  end

  // IF/ID: flush beats stall, stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (hz.FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (!hz.StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
    end
  end

  // ID/EX: capture decode every cycle, or insert a full bubble on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e   <= CTRL_BUBBLE;
      rd1_e    <= '0;
      rd2_e    <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      ImmExtE  <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else if (hz.FlushE) begin
      ctrl_e   <= CTRL_BUBBLE;
      rd1_e    <= '0;
      rd2_e    <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      ImmExtE  <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
    end else begin
      ctrl_e   <= ctrl_d;
      rd1_e    <= RD1D;
      rd2_e    <= RD2D;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      ImmExtE  <= ImmExtD;
      Rs1E     <= Rs1D;
      Rs2E     <= Rs2D;
      RdE      <= RdD;
    end
  end

  assign RegWriteE   = ctrl_e.RegWrite;
  assign ResultSrcE  = ctrl_e.ResultSrc;
  assign MemWriteE   = ctrl_e.MemWrite;
  assign JumpE       = ctrl_e.Jump;
  assign BranchE     = ctrl_e.Branch;
  assign ALUControlE = ctrl_e.ALUControl;
  assign ALUSrcE     = ctrl_e.ALUSrc;

  fwd_mux3 #(.WIDTH(WIDTH)) u_fwd_a (
    .sel     (hz.ForwardAE),
    .reg_val (rd1_e),
    .mem_val (ALUResultM),
    .wb_val  (ResultW),
    .y       (SrcAE)
  );

  fwd_mux3 #(.WIDTH(WIDTH)) u_fwd_b (
    .sel     (hz.ForwardBE),
    .reg_val (rd2_e),
    .mem_val (ALUResultM),
    .wb_val  (ResultW),
    .y       (WriteDataE)
  );

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed bench for pipe_ctrl_regs: a stage-level model checked every
// cycle, plus literal expectations for the key hazard scenarios.
module tb_pipe_ctrl_regs;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCNextF, InstrF, PCPlus4F, RD1D, RD2D, ImmExtD, ALUResultM, ResultW;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, PCE, PCPlus4E, ImmExtE, SrcAE, WriteDataE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 0;

  pipe_ctrl_regs_if hz ();

  pipe_ctrl_regs dut (
    .clk(clk), .rst_n(rst_n), .hz(hz),
    .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .SrcAE(SrcAE), .WriteDataE(WriteDataE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view of the three pipeline registers.
  typedef struct {
    logic [31:0] pcf, instrd, pcd, pcp4d;
    logic        regw, memw, jump, branch, alusrc;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
    logic [31:0] rd1, rd2, pce, pcp4e, imm;
    logic [4:0]  rs1, rs2, rd;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t reset_state();
    mdl_t s;
    s.pcf = 32'h0; s.instrd = NOP; s.pcd = 32'h0; s.pcp4d = 32'h0;
    s.regw = 0; s.memw = 0; s.jump = 0; s.branch = 0; s.alusrc = 0;
    s.rsrc = 0; s.aluc = 0;
    s.rd1 = 0; s.rd2 = 0; s.pce = 0; s.pcp4e = 0; s.imm = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0;
    return s;
  endfunction

  function automatic mdl_t next_state(mdl_t s);
    mdl_t n = s;
    mdl_t z = reset_state();
    if (!hz.StallF) n.pcf = PCNextF;
    if (hz.FlushD) begin
      n.instrd = NOP; n.pcd = 0; n.pcp4d = 0;
    end else if (!hz.StallD) begin
      n.instrd = InstrF; n.pcd = s.pcf; n.pcp4d = PCPlus4F;
    end
    if (hz.FlushE) begin
      n.regw = z.regw; n.memw = z.memw; n.jump = z.jump; n.branch = z.branch;
      n.alusrc = z.alusrc; n.rsrc = z.rsrc; n.aluc = z.aluc;
      n.rd1 = z.rd1; n.rd2 = z.rd2; n.pce = z.pce; n.pcp4e = z.pcp4e;
      n.imm = z.imm; n.rs1 = z.rs1; n.rs2 = z.rs2; n.rd = z.rd;
    end else begin
      n.regw = RegWriteD; n.memw = MemWriteD; n.jump = JumpD; n.branch = BranchD;
      n.alusrc = ALUSrcD; n.rsrc = ResultSrcD; n.aluc = ALUControlD;
      n.rd1 = RD1D; n.rd2 = RD2D; n.pce = s.pcd; n.pcp4e = s.pcp4d;
      n.imm = ImmExtD; n.rs1 = Rs1D; n.rs2 = Rs2D; n.rd = RdD;
    end
    return n;
  endfunction

  function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] r,
                                      logic [31:0] mm, logic [31:0] w);
    if (sel == 2'd1) return mm;
    if (sel == 2'd2) return w;
    return r;
  endfunction

  // Model update mirrors the register's clock and asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m = reset_state();
    else        m = next_state(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("PCF", PCF, m.pcf);
      check("InstrD", InstrD, m.instrd);
      check("PCD", PCD, m.pcd);
      check("PCPlus4D", PCPlus4D, m.pcp4d);
      check("RegWriteE", {31'b0, RegWriteE}, {31'b0, m.regw});
      check("MemWriteE", {31'b0, MemWriteE}, {31'b0, m.memw});
      check("JumpE", {31'b0, JumpE}, {31'b0, m.jump});
      check("BranchE", {31'b0, BranchE}, {31'b0, m.branch});
      check("ALUSrcE", {31'b0, ALUSrcE}, {31'b0, m.alusrc});
      check("ResultSrcE", {30'b0, ResultSrcE}, {30'b0, m.rsrc});
      check("ALUControlE", {29'b0, ALUControlE}, {29'b0, m.aluc});
      check("PCE", PCE, m.pce);
      check("PCPlus4E", PCPlus4E, m.pcp4e);
      check("ImmExtE", ImmExtE, m.imm);
      check("Rs1E", {27'b0, Rs1E}, {27'b0, m.rs1});
      check("Rs2E", {27'b0, Rs2E}, {27'b0, m.rs2});
      check("RdE", {27'b0, RdE}, {27'b0, m.rd});
      check("SrcAE", SrcAE, fwd(hz.ForwardAE, m.rd1, ALUResultM, ResultW));
      check("WriteDataE", WriteDataE, fwd(hz.ForwardBE, m.rd2, ALUResultM, ResultW));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hazards(input logic sf, input logic sd, input logic fd, input logic fe);
    hz.StallF = sf; hz.StallD = sd; hz.FlushD = fd; hz.FlushE = fe;
  endtask

  initial begin
    rst_n = 1'b0;
    hazards(0, 0, 0, 0);
    hz.ForwardAE = 2'b00; hz.ForwardBE = 2'b00;
    PCNextF = 0; InstrF = 0; PCPlus4F = 0;
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = 0; ALUControlD = 0; RD1D = 0; RD2D = 0; ImmExtD = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; ALUResultM = 0; ResultW = 0;

    // Reset held across several edges.
    repeat (3) tick();
    chk_on = 1;
    check("reset PCF", PCF, 32'h0);
    check("reset InstrD", InstrD, NOP);
    check("reset RegWriteE", {31'b0, RegWriteE}, 32'h0);
    rst_n = 1'b1;
    PCNextF = 32'h4;
    tick();
    check("first fetch PCF", PCF, 32'h4);

    // Load addi x1,x0,10 into decode with matching decode controls.
    InstrF = 32'h00A0_0093; PCPlus4F = 32'h8; PCNextF = 32'h8;
    RegWriteD = 1; RdD = 5'd1; ImmExtD = 32'd10; ALUSrcD = 1;
    RD1D = 32'h11; RD2D = 32'h44; ALUResultM = 32'h22; ResultW = 32'h33;
    tick();
    check("load InstrD", InstrD, 32'h00A0_0093);
    check("load PCD", PCD, 32'h4);

    // Load-use stall: F and D hold, E gets a bubble.
    hazards(1, 1, 0, 1);
    PCNextF = 32'hC; InstrF = 32'hDEAD_BEEF; PCPlus4F = 32'h10;
    tick();
    check("load-use PCF hold", PCF, 32'h8);
    check("load-use InstrD hold", InstrD, 32'h00A0_0093);
    check("load-use RegWriteE", {31'b0, RegWriteE}, 32'h0);
    check("load-use RdE", {27'b0, RdE}, 32'h0);
    hazards(0, 0, 0, 0);
    tick();
    check("reissue RdE", {27'b0, RdE}, 32'h1);
    check("reissue RegWriteE", {31'b0, RegWriteE}, 32'h1);
    check("resume PCF", PCF, 32'hC);

    // Forwarding sweep with RD1E=0x11, RD2E=0x44, M=0x22, W=0x33.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_a [4];
      exp_a = '{32'h11, 32'h22, 32'h33, 32'h11};
      hz.ForwardAE = 2'(i);
      #1;
      check("SrcAE sweep", SrcAE, exp_a[i]);
      tick();
    end
    hz.ForwardAE = 2'b00;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_b [4];
      exp_b = '{32'h44, 32'h22, 32'h33, 32'h44};
      hz.ForwardBE = 2'(i);
      #1;
      check("WriteDataE sweep", WriteDataE, exp_b[i]);
      tick();
    end
    hz.ForwardBE = 2'b00;

    // Taken branch: both D and E bubble, PC redirects.
    MemWriteD = 1; JumpD = 1; BranchD = 1;
    hazards(0, 0, 1, 1);
    PCNextF = 32'h40;
    tick();
    check("branch PCF", PCF, 32'h40);
    check("branch InstrD", InstrD, NOP);
    check("branch PCD", PCD, 32'h0);
    check("branch RegWriteE", {31'b0, RegWriteE}, 32'h0);
    check("branch MemWriteE", {31'b0, MemWriteE}, 32'h0);
    check("branch JumpE", {31'b0, JumpE}, 32'h0);
    check("branch BranchE", {31'b0, BranchE}, 32'h0);
    check("branch SrcAE", SrcAE, 32'h0);

    // Flush wins over stall in IF/ID.
    hazards(0, 0, 0, 0);
    InstrF = 32'h1234_5678; PCNextF = 32'h44;
    tick();
    check("pre-flush InstrD", InstrD, 32'h1234_5678);
    hazards(0, 1, 1, 0);
    tick();
    check("flush over stall InstrD", InstrD, NOP);

    // Asynchronous reset between edges while fetch is stalled.
    hazards(1, 0, 0, 0);
    PCNextF = 32'h80;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset PCF", PCF, 32'h0);
    check("async reset InstrD", InstrD, NOP);
    tick();
    rst_n = 1'b1;
    tick();
    check("stalled after reset PCF", PCF, 32'h0);
    hazards(0, 0, 0, 0);
    PCNextF = 32'h4;
    tick();
    check("resume after reset PCF", PCF, 32'h4);

    // Mixed traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 24; i++) begin
      hazards(i % 5 == 1, i % 5 == 1, i % 7 == 3, (i % 5 == 1) || (i % 7 == 3));
      hz.ForwardAE = 2'(i);
      hz.ForwardBE = 2'(i >> 1);
      PCNextF = 32'h100 + 32'(i) * 4; PCPlus4F = 32'h104 + 32'(i) * 4;
      InstrF = $urandom; RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
      ALUResultM = $urandom; ResultW = $urandom;
      RegWriteD = 1'(i); MemWriteD = 1'(i >> 1); JumpD = 1'(i >> 2);
      BranchD = 1'(i >> 3); ALUSrcD = ~1'(i);
      ResultSrcD = 2'(i); ALUControlD = 3'(i);
      Rs1D = 5'(i); Rs2D = 5'(i + 7); RdD = 5'(i + 13);
      tick();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
